// File: rtl/spi_master.sv
// SPI mode-0 byte initiator, MSB first, one slave select. Every output is registered.
// A byte takes 17*HALF clk edges from acceptance to the rdy pulse; start is only looked at while idle.
module spi_master #(
  parameter int HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  output logic       rdy,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  output logic       ss_n,
  input  logic       miso
);

  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  tx_sh, tx_sh_nxt;
  logic [7:0]  rx_sh, rx_sh_nxt;
  logic [7:0]  out_data_nxt;
  logic        rdy_nxt, busy_nxt, sclk_nxt, mosi_nxt, ss_n_nxt;
  logic        cnt_done;

  assign cnt_done = (cnt == HALF_M1);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_cnt_nxt  = bit_cnt;
    tx_sh_nxt    = tx_sh;
    rx_sh_nxt    = rx_sh;
    out_data_nxt = out_data;
    rdy_nxt      = 1'b0;
    busy_nxt     = busy;
    sclk_nxt     = sclk;
    mosi_nxt     = mosi;
    ss_n_nxt     = ss_n;

    case (state)
      IDLE: begin
        if (start) begin
          tx_sh_nxt = in_data;
          mosi_nxt  = in_data[7];
          ss_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = LEAD;
        end
      end
      LEAD: begin
        if (cnt_done) begin
          sclk_nxt    = 1'b1;
          rx_sh_nxt   = {rx_sh[6:0], miso};
          bit_cnt_nxt = 4'd1;
          cnt_nxt     = '0;
          state_nxt   = SHIFT;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_done) begin
          cnt_nxt = '0;
          if (sclk) begin
            sclk_nxt = 1'b0;
            if (bit_cnt < 4'd8) begin
              // next bit goes out on the falling edge, half a period before the slave samples it
              tx_sh_nxt = {tx_sh[6:0], 1'b0};
              mosi_nxt  = tx_sh[6];
            end else begin
              state_nxt = TRAIL;
            end
          end else begin
            sclk_nxt    = 1'b1;
            rx_sh_nxt   = {rx_sh[6:0], miso};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      TRAIL: begin
        if (cnt_done) begin
          ss_n_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          out_data_nxt = rx_sh;
          rdy_nxt      = 1'b1;
          cnt_nxt      = '0;
          bit_cnt_nxt  = '0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      out_data <= '0;
      rdy      <= 1'b0;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx_sh    <= tx_sh_nxt;
      rx_sh    <= rx_sh_nxt;
      out_data <= out_data_nxt;
      rdy      <= rdy_nxt;
      busy     <= busy_nxt;
      sclk     <= sclk_nxt;
      mosi     <= mosi_nxt;
      ss_n     <= ss_n_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Four initiators (HALF=1..4) share start/in_data/rst; each has its own miso source.
// A per-transfer timing model is checked every cycle, plus hand-computed expectations per scenario.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [7:0] in_data;
  logic [3:0] sclk_v, mosi_v, ss_v, busy_v, rdy_v, miso_v;
  logic [7:0] out_v [4];
  logic [7:0] slv = 8'h5A;

  // inst0/1: loopback, inst2: model slave sending 5A, inst3: miso tied high
  assign miso_v = {1'b1, slv[7], mosi_v[1], mosi_v[0]};

  spi_master #(.HALF(1)) u_h1 (.clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .out_data(out_v[0]), .rdy(rdy_v[0]), .busy(busy_v[0]), .sclk(sclk_v[0]),
    .mosi(mosi_v[0]), .ss_n(ss_v[0]), .miso(miso_v[0]));
  spi_master #(.HALF(2)) u_h2 (.clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .out_data(out_v[1]), .rdy(rdy_v[1]), .busy(busy_v[1]), .sclk(sclk_v[1]),
    .mosi(mosi_v[1]), .ss_n(ss_v[1]), .miso(miso_v[1]));
  spi_master #(.HALF(3)) u_h3 (.clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .out_data(out_v[2]), .rdy(rdy_v[2]), .busy(busy_v[2]), .sclk(sclk_v[2]),
    .mosi(mosi_v[2]), .ss_n(ss_v[2]), .miso(miso_v[2]));
  spi_master #(.HALF(4)) u_h4 (.clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .out_data(out_v[3]), .rdy(rdy_v[3]), .busy(busy_v[3]), .sclk(sclk_v[3]),
    .mosi(mosi_v[3]), .ss_n(ss_v[3]), .miso(miso_v[3]));

  int         n_cmp = 0, n_err = 0, cyc = 0;
  int         hv [4] = '{1, 2, 3, 4};
  bit         armed = 1'b0;
  bit         act [4];
  int         k [4];
  logic [7:0] txb [4], eout [4];
  logic       imosi [4];

  int   q_rise1[$], q_rise3[$], q_rdy0[$], q_rdy1[$];
  logic [7:0] q_out0[$];
  logic q_bits3[$];
  int   busy3 = 0;
  logic [3:0] ps_sclk = 4'b0;
  logic ps_ss2 = 1'b0;

  task automatic chk(input string name, input int g, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s inst%0d cyc=%0d: got %0h, expected %0h", name, g, cyc, act_v, exp_v);
    end
  endtask

  function automatic logic [7:0] rx_of(input int g, input logic [7:0] t);
    case (g)
      0, 1:    return t;
      2:       return 8'h5A;
      default: return 8'hFF;
    endcase
  endfunction

  // Transfer model: k counts edges since acceptance; completion lands on k == 17*HALF.
  task automatic model_step();
    for (int g = 0; g < 4; g++) begin
      if (!rst) begin
        act[g] = 1'b0; k[g] = 0; eout[g] = 8'h00; imosi[g] = 1'b0;
      end else begin
        if (act[g] && k[g] == 17 * hv[g]) act[g] = 1'b0;
        if (act[g]) begin
          k[g]++;
          if (k[g] == 17 * hv[g]) begin
            eout[g]  = rx_of(g, txb[g]);
            imosi[g] = txb[g][0];
          end
        end else if (start) begin
          act[g] = 1'b1; k[g] = 0; txb[g] = in_data;
        end
      end
    end
    if (!rst) armed = 1'b1;
  endtask

  task automatic check_all();
    logic e_ss, e_busy, e_rdy, e_sclk, e_mosi;
    int   h, kk, idx;
    for (int g = 0; g < 4; g++) begin
      h = hv[g]; kk = k[g];
      if (act[g]) begin
        e_ss   = (kk >= 17 * h);
        e_busy = (kk < 17 * h);
        e_rdy  = (kk == 17 * h);
        e_sclk = (kk >= h) && (kk < 16 * h) && (((kk / h) % 2) == 1);
        idx    = kk / (2 * h);
        if (idx > 7) idx = 7;
        e_mosi = txb[g][7 - idx];
      end else begin
        e_ss = 1'b1; e_busy = 1'b0; e_rdy = 1'b0; e_sclk = 1'b0; e_mosi = imosi[g];
      end
      chk("ss_n", g, ss_v[g], e_ss);
      chk("busy", g, busy_v[g], e_busy);
      chk("rdy", g, rdy_v[g], e_rdy);
      chk("sclk", g, sclk_v[g], e_sclk);
      chk("mosi", g, mosi_v[g], e_mosi);
      chk("out_data", g, out_v[g], eout[g]);
    end
  endtask

  task automatic monitor();
    if (sclk_v[1] && !ps_sclk[1]) q_rise1.push_back(cyc);
    if (sclk_v[3] && !ps_sclk[3]) begin
      q_rise3.push_back(cyc);
      q_bits3.push_back(mosi_v[3]);
    end
    if (rdy_v[0]) begin
      q_rdy0.push_back(cyc);
      q_out0.push_back(out_v[0]);
    end
    if (rdy_v[1]) q_rdy1.push_back(cyc);
    if (busy_v[3]) busy3++;
    // slave: loads on select, presents next bit after each falling sclk
    if (ps_ss2 && !ss_v[2]) slv = 8'h5A;
    else if (ps_sclk[2] && !sclk_v[2]) slv = {slv[6:0], 1'b0};
    ps_sclk = sclk_v;
    ps_ss2  = ss_v[2];
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    if (armed) check_all();
    monitor();
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (busy_v == 4'b0000) break;
      tick();
    end
    chk("idle_timeout", 0, busy_v, 4'b0000);
    tick();
    tick();
  endtask

  task automatic pulse(input logic [7:0] d, output int t0);
    in_data = d; start = 1'b1; t0 = cyc + 1;
    tick();
    start = 1'b0; in_data = 8'h00;
  endtask

  initial begin
    int t0, b0, b1, b3, b4;
    int exp_bits [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    rst = 1'b0; start = 1'b0; in_data = 8'h00;
    @(negedge clk);
    tick(); tick();
    rst = 1'b1;
    chk("rst_ss_n", 1, ss_v[1], 1'b1);
    chk("rst_sclk", 1, sclk_v[1], 1'b0);
    chk("rst_mosi", 1, mosi_v[1], 1'b0);
    chk("rst_busy", 1, busy_v[1], 1'b0);
    chk("rst_rdy", 1, rdy_v[1], 1'b0);
    chk("rst_out", 1, out_v[1], 8'h00);
    tick();

    // A5 single byte
    b0 = q_rise1.size(); b1 = q_rdy1.size(); busy3 = 0;
    pulse(8'hA5, t0);
    wait_idle(100);
    chk("h2_rise_count", 1, q_rise1.size() - b0, 8);
    for (int i = 0; i < 8; i++)
      if (q_rise1.size() > b0 + i) chk("h2_rise_time", 1, q_rise1[b0 + i] - t0, 2 + 4 * i);
    chk("h2_rdy_count", 1, q_rdy1.size() - b1, 1);
    if (q_rdy1.size() > b1) chk("h2_rdy_time", 1, q_rdy1[b1] - t0, 34);
    chk("h2_out", 1, out_v[1], 8'hA5);
    chk("h1_out", 0, out_v[0], 8'hA5);
    chk("h3_slave_out", 2, out_v[2], 8'h5A);
    chk("h3_sclk_idle", 2, sclk_v[2], 1'b0);
    chk("h4_out", 3, out_v[3], 8'hFF);
    chk("h4_busy_cycles", 3, busy3, 68);

    // 81 with miso high on HALF=4
    b3 = q_bits3.size(); b4 = q_rise3.size(); busy3 = 0;
    pulse(8'h81, t0);
    wait_idle(100);
    chk("h4_bits_count", 3, q_bits3.size() - b3, 8);
    for (int i = 0; i < 8; i++)
      if (q_bits3.size() > b3 + i) chk("h4_mosi_bit", 3, q_bits3[b3 + i], exp_bits[i]);
    if (q_rise3.size() > b4 + 1) chk("h4_sclk_period", 3, q_rise3[b4 + 1] - q_rise3[b4], 8);
    chk("h4_out_ff", 3, out_v[3], 8'hFF);
    chk("h4_busy_cycles2", 3, busy3, 68);

    // start held: back-to-back 3C then C3 on HALF=1
    b0 = q_rdy0.size();
    in_data = 8'h3C; start = 1'b1; t0 = cyc + 1;
    tick();
    in_data = 8'hC3;
    while (cyc < t0 + 18) tick();
    start = 1'b0; in_data = 8'h00;
    wait_idle(150);
    chk("b2b_rdy_count", 0, q_rdy0.size() - b0, 2);
    if (q_rdy0.size() > b0 + 1) begin
      chk("b2b_rdy1_time", 0, q_rdy0[b0] - t0, 17);
      chk("b2b_rdy2_time", 0, q_rdy0[b0 + 1] - t0, 35);
      chk("b2b_out1", 0, q_out0[b0], 8'h3C);
      chk("b2b_out2", 0, q_out0[b0 + 1], 8'hC3);
    end

    // inputs disturbed mid-byte
    pulse(8'h96, t0);
    for (int i = 0; i < 14; i++) begin
      start = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      tick();
    end
    start = 1'b0; in_data = 8'h00;
    wait_idle(100);
    chk("disturb_h1", 0, out_v[0], 8'h96);
    chk("disturb_h2", 1, out_v[1], 8'h96);

    // reset at T0+10
    pulse(8'hE7, t0);
    while (cyc < t0 + 9) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_ss_n", 1, ss_v[1], 1'b1);
    chk("mid_rst_sclk", 1, sclk_v[1], 1'b0);
    chk("mid_rst_busy", 1, busy_v[1], 1'b0);
    chk("mid_rst_rdy", 1, rdy_v[1], 1'b0);
    chk("mid_rst_out", 1, out_v[1], 8'h00);
    tick();
    pulse(8'h6B, t0);
    wait_idle(100);
    chk("after_rst_h2", 1, out_v[1], 8'h6B);
    chk("after_rst_h3", 2, out_v[2], 8'h5A);
    chk("after_rst_h4", 3, out_v[3], 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
